poci_inputs: RTL and testbench

Parametrised POCI input peripheral on the POCI bus behind the HASTI-to-POCI bridge, next to `poci_leds`. It generalises the fixed key/switch port to `N_IN` channels. Each channel is synchronised and debounced, and rising and falling edges are captured in sticky write-1-to-clear registers. An optional level interrupt summarises enabled edge flags for the core.

---
 rtl/pk_poci.sv | 22 ++
 rtl/if_poci.sv | 16 +
 rtl/input_debounce.sv | 57 +++++
 rtl/poci_inputs.sv | 135 +++++++++++++
 tb/tb_poci_inputs.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pk_poci.sv
// Shared POCI definitions for the input peripheral: base address, register
// word offsets and the control FSM encoding.
package pk_poci;

  localparam logic [31:0] POCI_INPUTS_BASE = 32'h4000_0010;

  // Word index taken from paddr[3:2].
  typedef enum logic [1:0] {
    REG_STATE  = 2'd0,
    REG_RISE   = 2'd1,
    REG_FALL   = 2'd2,
    REG_IRQ_EN = 2'd3
  } poci_inputs_reg_e;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } inputs_fsm_e;

  localparam int PRIME_CYCLES = 3;

endpackage

// File: rtl/if_poci.sv
// Zero-wait-state POCI bus between the HASTI bridge and its peripherals.
interface if_poci;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave  (input psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input prdata, pready, pslverr);
endinterface

// File: rtl/input_debounce.sv
// One input channel: 2-flop synchroniser, saturating stability counter and
// debounced level, with single-cycle rise/fall pulses on acceptance.
module input_debounce #(
  parameter  int DEBOUNCE_CYCLES = 20000,
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  input  logic prime_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]    sync_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample, accept;

  assign sample = sync_q[1];
  assign accept = !prime_i && (sample != state_q) && (cnt_q == CW'(DEBOUNCE_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (prime_i) begin
      state_d = sample;
      cnt_d   = '0;
    end else if (sample == state_q) begin
      cnt_d = '0;
    end else if (accept) begin
      state_d = sample;
      cnt_d   = '0;
    end else begin
      // Only reached while cnt_q < DEBOUNCE_CYCLES, so this cannot wrap.
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = accept & sample;
  assign fall_o  = accept & ~sample;

endmodule

// File: rtl/poci_inputs.sv
// POCI input peripheral: N_IN debounced channels, sticky W1C edge flags and,
// with POCI_INPUTS_IRQ_EN defined, a masked level interrupt.
module poci_inputs
  import pk_poci::*;
#(
  parameter int N_IN            = 14,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic            clk,
  input  logic            reset,
  if_poci.slave           bus,
  input  logic [N_IN-1:0] din
`ifdef POCI_INPUTS_IRQ_EN
  ,
  output logic            irq
`endif
);

  inputs_fsm_e fsm_q, fsm_d;
  logic [1:0]  prime_cnt_q, prime_cnt_d;
  logic        prime;

  always_comb begin
    fsm_d       = fsm_q;
    prime_cnt_d = prime_cnt_q;
    prime       = 1'b0;
    case (fsm_q)
      PRIME: begin
        prime       = 1'b1;
        prime_cnt_d = prime_cnt_q + 2'd1;
        if (prime_cnt_q == 2'(PRIME_CYCLES - 1)) begin
          fsm_d       = RUN;
          prime_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= PRIME;
      prime_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  logic [N_IN-1:0] state, rise_p, fall_p;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .din_i   (din[g]),
      .prime_i (prime),
      .state_o (state[g]),
      .rise_o  (rise_p[g]),
      .fall_o  (fall_p[g])
    );
  end

  logic             access, addr_ok, wr;
  poci_inputs_reg_e reg_sel;
  logic [N_IN-1:0]  wdata, rd_n;
  logic             unused_ok;

  assign access    = bus.psel & bus.penable;
  assign addr_ok   = (bus.paddr[1:0] == 2'b00);
  assign wr        = access & bus.pwrite & addr_ok;
  assign reg_sel   = poci_inputs_reg_e'(bus.paddr[3:2]);
  assign wdata     = bus.pwdata[N_IN-1:0];
  assign unused_ok = ^bus.pwdata;

  logic [N_IN-1:0] rise_q, rise_d, fall_q, fall_d;

  // New edges are OR-ed in after the clear so a concurrent edge survives.
  always_comb begin
    rise_d = rise_q & ~((wr && reg_sel == REG_RISE) ? wdata : '0) | rise_p;
    fall_d = fall_q & ~((wr && reg_sel == REG_FALL) ? wdata : '0) | fall_p;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

`ifdef POCI_INPUTS_IRQ_EN
  logic [N_IN-1:0] irq_en_q, irq_en_d;
  logic            irq_q, irq_d;

  always_comb begin
    irq_en_d = (wr && reg_sel == REG_IRQ_EN) ? wdata : irq_en_q;
    irq_d    = |((rise_q | fall_q) & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd_n = '0;
    case (reg_sel)
      REG_STATE:  rd_n = state;
      REG_RISE:   rd_n = rise_q;
      REG_FALL:   rd_n = fall_q;
`ifdef POCI_INPUTS_IRQ_EN
      REG_IRQ_EN: rd_n = irq_en_q;
`else
      REG_IRQ_EN: rd_n = '0;
`endif
      default:    rd_n = '0;
    endcase
  end

  assign bus.prdata  = (access && addr_ok) ? 32'(rd_n) : 32'd0;
  assign bus.pslverr = access & ~addr_ok;
  assign bus.pready  = 1'b1;

endmodule

// File: tb/tb_poci_inputs.sv
// Directed bench for poci_inputs with N_IN=4, DEBOUNCE_CYCLES=4; irq checks
// are compiled in when POCI_INPUTS_IRQ_EN is defined.
module tb_poci_inputs;
  localparam int N = 4;
  localparam int D = 4;
`ifdef POCI_INPUTS_IRQ_EN
  localparam logic [31:0] IRQ_EN_RB = 32'h4;
`else
  localparam logic [31:0] IRQ_EN_RB = 32'h0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] din;
  if_poci       bus_if ();
`ifdef POCI_INPUTS_IRQ_EN
  logic         irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poci_inputs #(.N_IN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .din   (din)
`ifdef POCI_INPUTS_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic e);
    bus_if.psel = 1'b1; bus_if.penable = 1'b1; bus_if.pwrite = 1'b0; bus_if.paddr = a;
    #1;
    d = bus_if.prdata;
    e = bus_if.pslverr;
    bus_if.psel = 1'b0; bus_if.penable = 1'b0;
    #1;
  endtask

  // Setup phase, then access phase; commits on the second edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] v, output logic e);
    bus_if.psel = 1'b1; bus_if.penable = 1'b0; bus_if.pwrite = 1'b1;
    bus_if.paddr = a; bus_if.pwdata = v;
    step(1);
    bus_if.penable = 1'b1;
    #1;
    e = bus_if.pslverr;
    step(1);
    bus_if.psel = 1'b0; bus_if.penable = 1'b0; bus_if.pwrite = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;

  task automatic test_reset();
    reset = 1'b1; din = 4'b1010;
    step(3);
    n_tests++; if (bus_if.pready !== 1'b1) begin n_fail++; $display("FAIL rst_pready: got %b want 1", bus_if.pready); end
    n_tests++; if (bus_if.prdata !== 32'h0) begin n_fail++; $display("FAIL rst_prdata_idle: got %h want 0", bus_if.prdata); end
    n_tests++; if (bus_if.pslverr !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr: got %b want 0", bus_if.pslverr); end
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_state: got %h want 0", d); end
`ifdef POCI_INPUTS_IRQ_EN
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
`endif
    reset = 1'b0;
    step(3);
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'hA) begin n_fail++; $display("FAIL prime_state: got %h want a", d); end
    step(8);
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL prime_rise: got %h want 0", d); end
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL prime_fall: got %h want 0", d); end
  endtask

  task automatic test_edge();
    din = 4'b1011;
    step(6);
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'hA) begin n_fail++; $display("FAIL edge_early_state: got %h want a", d); end
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_early_rise: got %h want 0", d); end
    step(1);
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'hB) begin n_fail++; $display("FAIL edge_state: got %h want b", d); end
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL edge_rise: got %h want 1", d); end
  endtask

  task automatic test_glitch();
    din = 4'b1001;
    step(3);
    din = 4'b1011;
    step(10);
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'hB) begin n_fail++; $display("FAIL glitch_state: got %h want b", d); end
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_fall: got %h want 0", d); end
  endtask

  task automatic test_bus_err();
    rd(4'h2, d, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_rd_pslverr: got %b want 1", e); end
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL err_rd_prdata: got %h want 0", d); end
    wr(4'h5, 32'hF, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_wr_pslverr: got %b want 1", e); end
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL err_wr_noeffect: got %h want 1", d); end
    wr(4'h0, 32'hF, e);
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL state_wr_pslverr: got %b want 0", e); end
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'hB) begin n_fail++; $display("FAIL state_wr_ignored: got %h want b", d); end
  endtask

  task automatic test_w1c();
    din = 4'b1010;
    step(8);
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_fall_set: got %h want 1", d); end
    // Access phase ends on the same edge that accepts the new rise.
    din = 4'b1011;
    step(5);
    wr(4'h4, 32'h1, e);
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_set_wins: got %h want 1", d); end
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'hB) begin n_fail++; $display("FAIL w1c_state: got %h want b", d); end
    wr(4'h4, 32'h1, e);
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_rise_clear: got %h want 0", d); end
    wr(4'h8, 32'h1, e);
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_fall_clear: got %h want 0", d); end
  endtask

  task automatic test_irq();
    din = 4'b1111;
    step(8);
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL irq_rise2: got %h want 4", d); end
    wr(4'h4, 32'hF, e);
    wr(4'hC, 32'h4, e);
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL irq_en_wr_pslverr: got %b want 0", e); end
    rd(4'hC, d, e);
    n_tests++; if (d !== IRQ_EN_RB) begin n_fail++; $display("FAIL irq_en_rb: got %h want %h", d, IRQ_EN_RB); end
    din = 4'b1011;
    step(7);
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL irq_fall2: got %h want 4", d); end
`ifdef POCI_INPUTS_IRQ_EN
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_pre: got %b want 0", irq); end
    step(1);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
    wr(4'h8, 32'h4, e);
    step(1);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
`else
    wr(4'h8, 32'h4, e);
`endif
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL irq_fall_clear: got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    din = 4'b0011;
    step(5);
    reset = 1'b1;
    step(2);
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_state: got %h want 0", d); end
    rd(4'hC, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rst_irq_en: got %h want 0", d); end
    reset = 1'b0;
    step(3);
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL mid_prime_state: got %h want 3", d); end
    step(10);
    rd(4'h4, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rise: got %h want 0", d); end
    rd(4'h8, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_fall: got %h want 0", d); end
    rd(4'h0, d, e);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL mid_state: got %h want 3", d); end
`ifdef POCI_INPUTS_IRQ_EN
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b want 0", irq); end
`endif
  endtask

  initial begin
    bus_if.psel = 1'b0; bus_if.penable = 1'b0; bus_if.pwrite = 1'b0;
    bus_if.paddr = 4'h0; bus_if.pwdata = 32'h0;
    test_reset();
    test_edge();
    test_glitch();
    test_bus_err();
    test_w1c();
    test_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
